// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/stop sequencer feeding SongPlayer's playSound and the flash LED.
// Buttons are edge-detected here; all outputs are registered (one clk after the inputs).
module alarm_sequencer #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_1hz_i,
  input  logic [4:0] cur_hr_i,
  input  logic [5:0] cur_min_i,
  input  logic [4:0] alm_hr_i,
  input  logic [5:0] alm_min_i,
  input  logic       alm_en_i,
  input  logic       snooze_btn_i,
  input  logic       stop_btn_i,
  output logic       play_sound_o,
  output logic       flash_o,
  output logic [1:0] state_o,
  output logic [1:0] snooze_cnt_o
);

  localparam int MAX_SEC = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int SEC_W   = $clog2(MAX_SEC + 1);

  localparam logic [SEC_W-1:0] SNOOZE_LIM = SEC_W'(SNOOZE_SEC);
  localparam logic [SEC_W-1:0] RING_LIM   = SEC_W'(RING_TIMEOUT_SEC);
  localparam logic [SEC_W-1:0] SEC_SAT    = SEC_W'(MAX_SEC);
  localparam logic [1:0]       SNZ_LIM    = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [1:0]       snz_cnt_q, snz_cnt_d;
  logic             flash_q, flash_d;
  logic             play_q, play_d;
  logic             snz_btn_q, stop_btn_q;

  logic             match;
  logic             snz_press, stop_press;
  logic [SEC_W-1:0] sec_inc;

  assign match      = alm_en_i & (cur_hr_i == alm_hr_i) & (cur_min_i == alm_min_i);
  assign snz_press  = snooze_btn_i & ~snz_btn_q;
  assign stop_press = stop_btn_i & ~stop_btn_q;
  // Saturating increment so the counter can never wrap back below a limit.
  assign sec_inc    = (sec_q == SEC_SAT) ? sec_q : sec_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    snz_cnt_d = snz_cnt_q;
    flash_d   = flash_q;

    if (!alm_en_i) begin
      state_d   = IDLE;
      sec_d     = '0;
      snz_cnt_d = '0;
      flash_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d = RINGING;
            sec_d   = '0;
            flash_d = 1'b0;
          end
        end

        RINGING: begin
          if (stop_press) begin
            state_d = DONE;
            sec_d   = '0;
            flash_d = 1'b0;
          end else if (snz_press && (snz_cnt_q < SNZ_LIM)) begin
            state_d   = SNOOZE;
            sec_d     = '0;
            snz_cnt_d = snz_cnt_q + 2'd1;
            flash_d   = 1'b0;
          end else if (tick_1hz_i) begin
            if (sec_inc >= RING_LIM) begin
              state_d = DONE;
              sec_d   = '0;
              flash_d = 1'b0;
            end else begin
              sec_d   = sec_inc;
              flash_d = ~flash_q;
            end
          end
        end

        SNOOZE: begin
          flash_d = 1'b0;
          if (stop_press) begin
            state_d = DONE;
            sec_d   = '0;
          end else if (tick_1hz_i) begin
            if (sec_inc >= SNOOZE_LIM) begin
              state_d = RINGING;
              sec_d   = '0;
            end else begin
              sec_d = sec_inc;
            end
          end
        end

        DONE: begin
          flash_d = 1'b0;
          // Held here until the matching minute passes so it cannot retrigger.
          if (!match) begin
            state_d   = IDLE;
            sec_d     = '0;
            snz_cnt_d = '0;
          end
        end

        default: begin
          state_d   = IDLE;
          sec_d     = '0;
          snz_cnt_d = '0;
          flash_d   = 1'b0;
        end
      endcase
    end

    play_d = (state_d == RINGING);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      snz_cnt_q  <= '0;
      flash_q    <= 1'b0;
      play_q     <= 1'b0;
      snz_btn_q  <= 1'b0;
      stop_btn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      snz_cnt_q  <= snz_cnt_d;
      flash_q    <= flash_d;
      play_q     <= play_d;
      snz_btn_q  <= snooze_btn_i;
      stop_btn_q <= stop_btn_i;
    end
  end

  assign play_sound_o = play_q;
  assign flash_o      = flash_q;
  assign state_o      = state_q;
  assign snooze_cnt_o = snz_cnt_q;

endmodule
